array_bank_regfile: RTL and testbench

- Parametrised multi-bank array store: BANKS banks × DEPTH entries × WIDTH bits, held in registers.
- One write port, one registered read port.
- Built-in clear sequencer fills every entry with CLEAR_VALUE after reset or on request.
- Successor to the fixed-size packed/unpacked array assignments: adds runtime addressing, clocked storage and a sequenced clear.

---
 rtl/array_bank_regfile.sv | 185 ++++++++++++++++++
 tb/tb_array_bank_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/array_bank_regfile.sv
// Banked register-array store with one write port, one registered read port and
// a sequenced clear that fills every entry with CLEAR_VALUE after reset or on request.
// Optional parity storage is enabled by defining ARRAY_BANK_REGFILE_PARITY_EN.
module array_bank_regfile #(
   parameter int unsigned WIDTH       = 10,
   parameter int unsigned DEPTH       = 10,
   parameter int unsigned BANKS       = 2,
   parameter int unsigned CLEAR_VALUE = 1,
   localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [BW-1:0]    i_wr_bank,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
`ifdef ARRAY_BANK_REGFILE_PARITY_EN
   input  logic             i_wr_perr_inject,
   output logic             o_rd_perr,
`endif
   input  logic             i_rd_en,
   input  logic [BW-1:0]    i_rd_bank,
   input  logic [AW-1:0]    i_rd_addr,
   output logic             o_rd_valid,
   output logic [WIDTH-1:0] o_rd_data,
   input  logic             i_clear,
   output logic             o_busy
);

   localparam logic [WIDTH-1:0] ClearWord = WIDTH'(CLEAR_VALUE);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] mem_q [BANKS][DEPTH];
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic clear_we, wr_in_range, rd_in_range, wr_acc, rd_acc, fwd;

   assign o_busy      = (state_q == StClear);
   assign clear_we    = o_busy && !i_rst;
   assign wr_in_range = (32'(i_wr_bank) < BANKS) && (32'(i_wr_addr) < DEPTH);
   assign rd_in_range = (32'(i_rd_bank) < BANKS) && (32'(i_rd_addr) < DEPTH);
   // A clear request in the same cycle takes priority over the write.
   assign wr_acc      = i_wr_en && !o_busy && !i_clear && !i_rst && wr_in_range;
   assign rd_acc      = i_rd_en && !o_busy && !i_rst;
   assign fwd         = wr_acc && (i_wr_bank == i_rd_bank) && (i_wr_addr == i_rd_addr);

   // Clear sequencer state and pointer register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StClear;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Clear sequencer next-state: one entry per cycle across all banks.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (i_clear) begin
               state_d = StClear;
               ptr_d   = '0;
            end
         end
         StClear: begin
            if (32'(ptr_q) >= DEPTH - 1) begin
               state_d = StIdle;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = StClear;
            ptr_d   = '0;
         end
      endcase
   end

   // Storage update: clear row write or single accepted write.
   always_ff @(posedge i_clk) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
         for (int unsigned d = 0; d < DEPTH; d++) begin
            if (clear_we && (32'(ptr_q) == d)) begin
               mem_q[b][d] <= ClearWord;
            end else if (wr_acc && (32'(i_wr_bank) == b) && (32'(i_wr_addr) == d)) begin
               mem_q[b][d] <= i_wr_data;
            end
         end
      end
   end

   // Read mux with write-first forwarding; out-of-range reads return zero.
   always_comb begin
      logic [WIDTH-1:0] word;
      word = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         for (int unsigned d = 0; d < DEPTH; d++) begin
            if ((32'(i_rd_bank) == b) && (32'(i_rd_addr) == d)) begin
               word = mem_q[b][d];
            end
         end
      end
      if (fwd) begin
         word = i_wr_data;
      end
      if (!rd_in_range) begin
         word = '0;
      end
      rd_valid_d = rd_acc;
      rd_data_d  = rd_acc ? word : rd_data_q;
   end

   // Registered read outputs; data holds when no read is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign o_rd_valid = rd_valid_q;
   assign o_rd_data  = rd_data_q;

`ifdef ARRAY_BANK_REGFILE_PARITY_EN
   logic par_q [BANKS][DEPTH];
   logic rd_perr_q, rd_perr_d;

   // Parity storage: even parity of the data, optionally inverted on injection.
   always_ff @(posedge i_clk) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
         for (int unsigned d = 0; d < DEPTH; d++) begin
            if (clear_we && (32'(ptr_q) == d)) begin
               par_q[b][d] <= ^ClearWord;
            end else if (wr_acc && (32'(i_wr_bank) == b) && (32'(i_wr_addr) == d)) begin
               par_q[b][d] <= (^i_wr_data) ^ i_wr_perr_inject;
            end
         end
      end
   end

   // Parity check on the read word; a forwarded write mismatches only when injected.
   always_comb begin
      logic par, dat_par;
      par     = 1'b0;
      dat_par = 1'b0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         for (int unsigned d = 0; d < DEPTH; d++) begin
            if ((32'(i_rd_bank) == b) && (32'(i_rd_addr) == d)) begin
               par     = par_q[b][d];
               dat_par = ^mem_q[b][d];
            end
         end
      end
      rd_perr_d = 1'b0;
      if (rd_acc && rd_in_range) begin
         rd_perr_d = fwd ? i_wr_perr_inject : (par != dat_par);
      end
   end

   // Parity error flag registered alongside read valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_perr_q <= 1'b0;
      end else begin
         rd_perr_q <= rd_perr_d;
      end
   end

   assign o_rd_perr = rd_perr_q;
`endif

endmodule

// File: tb/tb_array_bank_regfile.sv
// Directed self-checking bench for array_bank_regfile (default parameters).
module tb_array_bank_regfile;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en, clear;
   logic [0:0] wr_bank, rd_bank;
   logic [3:0] wr_addr, rd_addr;
   logic [9:0] wr_data, rd_data;
   logic       rd_valid, busy;
`ifdef ARRAY_BANK_REGFILE_PARITY_EN
   logic       perr_inject, rd_perr;
`endif

   int checks = 0;
   int errors = 0;
   int model [2][10];

   array_bank_regfile dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (wr_en),
      .i_wr_bank  (wr_bank),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
`ifdef ARRAY_BANK_REGFILE_PARITY_EN
      .i_wr_perr_inject (perr_inject),
      .o_rd_perr  (rd_perr),
`endif
      .i_rd_en    (rd_en),
      .i_rd_bank  (rd_bank),
      .i_rd_addr  (rd_addr),
      .o_rd_valid (rd_valid),
      .o_rd_data  (rd_data),
      .i_clear    (clear),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts samples with busy high; checks no read completes during them.
   task automatic count_busy(input bit skip_first, output int n);
      n = 0;
      while (busy && n < 40) begin
         if (!(skip_first && n == 0)) check("busy_no_valid", 32'(rd_valid), 0);
         tick();
         n++;
      end
   endtask

   task automatic do_read(input int b, input int a, input int exp);
      rd_en   = 1'b1;
      rd_bank = 1'(b);
      rd_addr = 4'(a);
      tick();
      rd_en = 1'b0;
      check($sformatf("rd_valid b%0d a%0d", b, a), 32'(rd_valid), 1);
      check($sformatf("rd_data b%0d a%0d", b, a), 32'(rd_data), 32'(exp));
   endtask

   task automatic do_write(input int b, input int a, input int d);
      wr_en   = 1'b1;
      wr_bank = 1'(b);
      wr_addr = 4'(a);
      wr_data = 10'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic read_all();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 10; a++)
            do_read(b, a, model[b][a]);
   endtask

   initial begin
      int n;
      rst = 1'b1; wr_en = 0; rd_en = 0; clear = 0;
      wr_bank = 0; wr_addr = 0; wr_data = 0; rd_bank = 0; rd_addr = 0;
`ifdef ARRAY_BANK_REGFILE_PARITY_EN
      perr_inject = 0;
`endif
      for (int b = 0; b < 2; b++) for (int a = 0; a < 10; a++) model[b][a] = 1;

      tick();
      tick();
      check("reset_valid", 32'(rd_valid), 0);
      check("reset_data", 32'(rd_data), 0);
      check("reset_busy", 32'(busy), 1);

      // Initial clear with a read request held high throughout.
      rd_en = 1'b1;
      rst   = 1'b0;
      count_busy(1'b0, n);
      check("init_clear_len", 32'(n), 10);
      check("post_clear_valid", 32'(rd_valid), 0);
      rd_en = 1'b0;
      read_all();

      // No read: valid drops, data holds.
      tick();
      check("idle_valid", 32'(rd_valid), 0);
      check("idle_hold", 32'(rd_data), 1);

      // Plain write then read.
      do_write(1, 7, 'h2A5);
      model[1][7] = 'h2A5;
      do_read(1, 7, 'h2A5);
      do_read(0, 7, 1);

      // Same-cycle write and read: write-first.
      wr_en = 1; wr_bank = 0; wr_addr = 3; wr_data = 10'h155;
      rd_en = 1; rd_bank = 0; rd_addr = 3;
      tick();
      wr_en = 0; rd_en = 0;
      model[0][3] = 'h155;
      check("wf_valid", 32'(rd_valid), 1);
      check("wf_data", 32'(rd_data), 'h155);
      do_read(0, 3, 'h155);

      // Out-of-range write dropped; out-of-range read returns zero.
      do_write(0, 10, 'h3FF);
      do_write(1, 15, 'h3FF);
      do_read(0, 10, 0);
      do_read(1, 15, 0);
      read_all();

`ifdef ARRAY_BANK_REGFILE_PARITY_EN
      perr_inject = 1;
      do_write(0, 2, 'h0F0);
      perr_inject = 0;
      do_read(0, 2, 'h0F0);
      check("perr_injected", 32'(rd_perr), 1);
      do_write(0, 2, 'h0F0);
      do_read(0, 2, 'h0F0);
      check("perr_clean", 32'(rd_perr), 0);
      do_read(0, 12, 0);
      check("perr_oor", 32'(rd_perr), 0);
      model[0][2] = 'h0F0;
`endif

      // Clear with simultaneous write (dropped) and read (pre-clear contents).
      clear = 1; wr_en = 1; wr_bank = 0; wr_addr = 0; wr_data = 10'h3FF;
      rd_en = 1; rd_bank = 1; rd_addr = 7;
      tick();
      clear = 0; wr_en = 0;
      check("clr_rd_valid", 32'(rd_valid), 1);
      check("clr_rd_data", 32'(rd_data), 'h2A5);
      check("clr_busy", 32'(busy), 1);
      // Four clear rows written, clear request while busy is ignored.
      clear = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("clr_busy_mid", 32'(busy), 1);
         check("clr_mid_valid", 32'(rd_valid), 0);
      end
      clear = 0;
      // Reset at clear cycle 4 restarts the sequence.
      rst = 1;
      tick();
      rst = 0;
      check("rst_mid_busy", 32'(busy), 1);
      count_busy(1'b0, n);
      check("restart_clear_len", 32'(n), 10);
      rd_en = 0;
      for (int b = 0; b < 2; b++) for (int a = 0; a < 10; a++) model[b][a] = 1;
      read_all();

      // Uninterrupted requested clear lasts DEPTH cycles.
      do_write(0, 5, 'h0AA);
      clear = 1;
      tick();
      clear = 0;
      count_busy(1'b0, n);
      check("req_clear_len", 32'(n), 10);
      do_read(0, 5, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
